// File: rtl/fir_feeder.sv
// fir_feeder: buffers upstream sample and coefficient words and feeds them to
// a FIR filter through a one-cycle strobe / modwait handshake.
//
// Ports
//   clk, n_rst             system clock, asynchronous active-low reset
//   in_valid, in_data,     upstream word; in_is_coeff selects coefficient (1)
//   in_is_coeff, in_ready    or sample (0); accepted on in_valid & in_ready
//   clr                    synchronous clear of FIFO, coefficient state, timeout
//   modwait                filter busy indication
//   sample_data            registered sample, valid from data_ready onwards
//   fir_coefficient        registered coefficient, valid from load_coeff onwards
//   data_ready, load_coeff one-cycle strobes
//   fifo_count             sample FIFO occupancy 0..8
//   timeout                sticky handshake-timeout flag
//
// Build option: define FIR_FEEDER_TIMEOUT_EN to abort a WAIT state after 16
// cycles without the awaited modwait level; otherwise WAIT states never expire
// and timeout is tied low.
//
// state     | meaning
// IDLE      | nothing in flight; coefficient load wins over samples
// C_PULSE   | latch bank[k] into fir_coefficient, strobe load_coeff
// C_WAIT_HI | wait for filter to raise modwait
// C_WAIT_LO | wait for modwait low, then next coefficient or done
// S_PULSE   | pop FIFO head into sample_data, strobe data_ready
// S_WAIT_HI | wait for filter to raise modwait
// S_WAIT_LO | wait for modwait low, then back to IDLE
module fir_feeder (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic        in_is_coeff,
   output logic        in_ready,
   input  logic        clr,
   input  logic        modwait,
   output logic [15:0] sample_data,
   output logic [15:0] fir_coefficient,
   output logic        data_ready,
   output logic        load_coeff,
   output logic [3:0]  fifo_count,
   output logic        timeout
);

   typedef enum logic [2:0] {
      IDLE, C_PULSE, C_WAIT_HI, C_WAIT_LO, S_PULSE, S_WAIT_HI, S_WAIT_LO
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] fifo_mem [8];
   logic [2:0]  wr_ptr, rd_ptr;
   logic [15:0] bank [4];
   logic [1:0]  widx, k;
   logic        coeff_pending;
   logic        push, pop, coeff_wr, k_inc, coeff_done, abort;

   // Readiness uses registered occupancy only, so a same-cycle pop never lets
   // a full FIFO accept.
   assign in_ready = in_is_coeff ? ~coeff_pending : (fifo_count < 4'd8);
   assign push     = in_valid & in_ready & ~in_is_coeff & ~clr;
   assign coeff_wr = in_valid & in_ready & in_is_coeff & ~clr;
   assign pop      = (state_q == S_PULSE) & ~clr;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      k_inc      = 1'b0;
      coeff_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (coeff_pending && !modwait)          state_d = C_PULSE;
            else if (fifo_count != 4'd0 && !modwait) state_d = S_PULSE;
         end
         C_PULSE:   state_d = C_WAIT_HI;
         C_WAIT_HI: begin
            if (abort) begin
               state_d    = IDLE;
               coeff_done = 1'b1;
            end else if (modwait) begin
               state_d = C_WAIT_LO;
            end
         end
         C_WAIT_LO: begin
            if (abort) begin
               state_d    = IDLE;
               coeff_done = 1'b1;
            end else if (!modwait) begin
               k_inc = 1'b1;
               if (k == 2'd3) begin
                  state_d    = IDLE;
                  coeff_done = 1'b1;
               end else begin
                  state_d = C_PULSE;
               end
            end
         end
         S_PULSE:   state_d = S_WAIT_HI;
         S_WAIT_HI: begin
            if (abort)        state_d = IDLE;
            else if (modwait) state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (abort || !modwait) state_d = IDLE;
         end
         default:   state_d = IDLE;
      endcase
      if (clr) state_d = IDLE;
   end

   // FIFO storage needs no reset; occupancy and pointers define its contents.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_count      <= '0;
         widx            <= '0;
         k               <= '0;
         coeff_pending   <= 1'b0;
         sample_data     <= '0;
         fir_coefficient <= '0;
         data_ready      <= 1'b0;
         load_coeff      <= 1'b0;
         for (int i = 0; i < 4; i++) bank[i] <= '0;
      end else begin
         data_ready <= pop;
         load_coeff <= (state_q == C_PULSE) & ~clr;
         if (state_q == C_PULSE && !clr) fir_coefficient <= bank[k];
         if (state_q == IDLE) k <= '0;
         else if (k_inc)      k <= k + 2'd1;
         if (clr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            widx          <= '0;
            coeff_pending <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 3'd1;
            if (pop) begin
               sample_data <= fifo_mem[rd_ptr];
               rd_ptr      <= rd_ptr + 3'd1;
            end
            case ({push, pop})
               2'b10:   fifo_count <= fifo_count + 4'd1;
               2'b01:   fifo_count <= fifo_count - 4'd1;
               default: fifo_count <= fifo_count;
            endcase
            // Bank is write-locked while pending, so a write and the end of a
            // load never coincide.
            if (coeff_wr) begin
               bank[widx] <= in_data;
               widx       <= widx + 2'd1;
               if (widx == 2'd3) coeff_pending <= 1'b1;
            end else if (coeff_done) begin
               coeff_pending <= 1'b0;
            end
         end
      end
   end

`ifdef FIR_FEEDER_TIMEOUT_EN
   logic [4:0] tmr;
   logic       timeout_q;

   // Down-counter reloads on every state change; terminal count in a WAIT
   // state without the awaited modwait level aborts the sequence.
   assign abort = (tmr == 5'd0) &&
                  (((state_q == C_WAIT_HI || state_q == S_WAIT_HI) && !modwait) ||
                   ((state_q == C_WAIT_LO || state_q == S_WAIT_LO) && modwait));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tmr       <= 5'd15;
         timeout_q <= 1'b0;
      end else begin
         if (clr || state_d != state_q) tmr <= 5'd15;
         else if (state_q == C_WAIT_HI || state_q == C_WAIT_LO ||
                  state_q == S_WAIT_HI || state_q == S_WAIT_LO) tmr <= tmr - 5'd1;
         if (clr)        timeout_q <= 1'b0;
         else if (abort) timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign abort   = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fir_feeder.sv
`timescale 1ns/1ps
module tb_fir_feeder;
   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_is_coeff = 1'b0;
   logic        clr = 1'b0;
   logic        modwait = 1'b0;
   logic        in_ready, data_ready, load_coeff, timeout;
   logic [15:0] sample_data, fir_coefficient;
   logic [3:0]  fifo_count;

   fir_feeder dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_data(in_data),
      .in_is_coeff(in_is_coeff), .in_ready(in_ready), .clr(clr), .modwait(modwait),
      .sample_data(sample_data), .fir_coefficient(fir_coefficient),
      .data_ready(data_ready), .load_coeff(load_coeff), .fifo_count(fifo_count),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model: sample queue, coefficient bank, pending flag
   logic [15:0] q[$];
   logic [15:0] bank_m [4];
   int          widx_m, pend_cyc, kcount, cdone_cyc, to_cyc, mw_left, fixed_r;
   bit          pend_m, cdone, exp_to, hold_mw, no_resp, prev_mw;
   logic [15:0] exp_sd, exp_fc;
   logic [15:0] sd_log[$], fc_log[$];
   int          dr_log[$], lc_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 4; i++) bank_m[i] = '0;
      widx_m = 0; kcount = 0; pend_m = 0; cdone = 0; exp_to = 0; to_cyc = -1;
      exp_sd = '0; exp_fc = '0; mw_left = 0; prev_mw = 0;
   endtask

   // One clock cycle: drive filter response, check, advance, update model, check.
   task automatic tick();
      bit acc_s, acc_c;
      modwait = hold_mw || (mw_left > 0);
      if (mw_left > 0) mw_left--;
      #1;
      chk("in_ready", in_ready, in_is_coeff ? !pend_m : (q.size() < 8));
      acc_s = in_valid && !in_is_coeff && (q.size() < 8) && !clr;
      acc_c = in_valid && in_is_coeff && !pend_m && !clr;
      prev_mw = modwait;
      @(posedge clk); #1; cyc++;
      if (clr) begin
         q.delete(); widx_m = 0; pend_m = 0; cdone = 0; exp_to = 0; to_cyc = -1;
      end else begin
         // a finished coefficient load releases pending at the first low modwait after its last strobe
         if (cdone && !prev_mw && (cyc - 1 > cdone_cyc)) begin pend_m = 0; cdone = 0; end
         if (acc_s) q.push_back(in_data);
         if (acc_c) begin
            bank_m[widx_m] = in_data;
            if (widx_m == 3) begin pend_m = 1; pend_cyc = cyc; widx_m = 0; kcount = 0; end
            else widx_m++;
         end
      end
      if (data_ready) begin
         chk("dr_fifo_nonempty", q.size() > (acc_s ? 1 : 0), 1);
         chk("dr_coeff_priority", pend_m && (pend_cyc <= cyc - 2), 0);
         if (q.size() > 0) exp_sd = q.pop_front();
         sd_log.push_back(exp_sd); dr_log.push_back(cyc);
         if (no_resp) to_cyc = cyc + 16;
         else mw_left = (fixed_r != 0) ? fixed_r : int'($urandom_range(1, 3));
      end
      if (load_coeff) begin
         chk("lc_pending", pend_m, 1);
         chk("lc_count", kcount < 4, 1);
         if (kcount < 4) exp_fc = bank_m[kcount];
         kcount++;
         if (kcount == 4) begin cdone = 1; cdone_cyc = cyc; end
         fc_log.push_back(exp_fc); lc_log.push_back(cyc);
         mw_left = (fixed_r != 0) ? fixed_r : int'($urandom_range(1, 3));
      end
      if (cyc == to_cyc) exp_to = 1;
      chk("fifo_count", fifo_count, q.size());
      chk("sample_data", sample_data, exp_sd);
      chk("fir_coefficient", fir_coefficient, exp_fc);
      chk("timeout", timeout, exp_to);
      chk("strobe_overlap", data_ready & load_coeff, 0);
   endtask

   task automatic push_word(input logic [15:0] d, input bit is_c);
      in_valid = 1'b1; in_data = d; in_is_coeff = is_c;
      tick();
      in_valid = 1'b0; in_is_coeff = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (n < 300 && (q.size() != 0 || pend_m || mw_left != 0)) begin tick(); n++; end
      chk("drain_done", (q.size() == 0) && !pend_m, 1);
      repeat (3) tick();
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_sample_data"}, sample_data, 16'h0000);
      chk({tag, "_fir_coefficient"}, fir_coefficient, 16'h0000);
      chk({tag, "_data_ready"}, data_ready, 0);
      chk({tag, "_load_coeff"}, load_coeff, 0);
      chk({tag, "_fifo_count"}, fifo_count, 4'd0);
      chk({tag, "_timeout"}, timeout, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cvals [4];
      int n0, sb, fb, db, n;
      fixed_r = 0; hold_mw = 0; no_resp = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      n_rst = 1'b1;

      // two samples into an empty FIFO, filter busy 3 cycles per strobe
      fixed_r = 3;
      push_word(16'h0010, 0);
      n0 = cyc;
      push_word(16'h0020, 0);
      n = 0;
      while (n < 50 && dr_log.size() < 2) begin tick(); n++; end
      chk("two_strobes", dr_log.size(), 2);
      if (dr_log.size() >= 2) begin
         chk("latency", dr_log[0] - n0, 2);
         chk("first_sample", sd_log[0], 16'h0010);
         chk("second_sample", sd_log[1], 16'h0020);
      end
      drain();
      chk("fifo_empty_after", fifo_count, 4'd0);

      // coefficient load takes priority over a queued sample
      cvals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      sb = sd_log.size(); fb = fc_log.size(); db = dr_log.size();
      hold_mw = 1;
      push_word(16'h0055, 0);
      for (int i = 0; i < 4; i++) push_word(cvals[i], 1);
      hold_mw = 0;
      drain();
      chk("coeff_strobes", fc_log.size() - fb, 4);
      chk("sample_after_coeff", sd_log.size() - sb, 1);
      if (fc_log.size() - fb == 4 && sd_log.size() - sb == 1) begin
         for (int i = 0; i < 4; i++) chk("coeff_value", fc_log[fb + i], cvals[i]);
         chk("queued_sample", sd_log[sb], 16'h0055);
         chk("coeff_before_sample", dr_log[db] > lc_log[fb + 3], 1);
      end

      // nine pushes with the filter busy: ninth dropped
      sb = sd_log.size();
      hold_mw = 1;
      for (int i = 0; i < 9; i++) push_word(16'h0100 + 16'(i), 0);
      chk("full_count", fifo_count, 4'd8);
      chk("full_in_ready", in_ready, 0);
      hold_mw = 0;
      drain();
      chk("full_drain_count", sd_log.size() - sb, 8);
      if (sd_log.size() - sb == 8)
         for (int i = 0; i < 8; i++) chk("full_order", sd_log[sb + i], 16'h0100 + 16'(i));

      // reset during C_WAIT_LO with k=2
      fb = fc_log.size();
      for (int i = 0; i < 4; i++) push_word(cvals[i], 1);
      n = 0;
      while (n < 60 && kcount < 3) begin tick(); n++; end
      chk("third_coeff_seen", kcount, 3);
      tick();
      n_rst = 1'b0;
      #1;
      check_zero_outputs("midreset");
      model_reset();
      repeat (2) begin @(posedge clk); #1; cyc++; end
      n_rst = 1'b1;
      tick();
      in_is_coeff = 1'b1;
      #1;
      chk("coeff_ready_after_reset", in_ready, 1);
      in_is_coeff = 1'b0;
      fb = fc_log.size();
      cvals = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
      for (int i = 0; i < 4; i++) push_word(cvals[i], 1);
      drain();
      chk("reload_strobes", fc_log.size() - fb, 4);
      if (fc_log.size() - fb == 4)
         for (int i = 0; i < 4; i++) chk("reload_value", fc_log[fb + i], cvals[i]);

`ifdef FIR_FEEDER_TIMEOUT_EN
      // filter never answers: timeout after 16 waiting cycles, cleared by clr
      no_resp = 1;
      push_word(16'h0077, 0);
      repeat (22) tick();
      chk("timeout_set", timeout, 1);
      no_resp = 0;
      clr = 1'b1; tick(); clr = 1'b0;
      tick();
      chk("timeout_cleared", timeout, 0);
      push_word(16'h0078, 0);
      drain();
`endif

      // randomized traffic with occasional clear
      fixed_r = 0;
      for (int i = 0; i < 800; i++) begin
         in_valid    = ($urandom_range(0, 1) == 1);
         in_is_coeff = ($urandom_range(0, 3) == 0);
         in_data     = 16'($urandom);
         clr         = ($urandom_range(0, 63) == 0);
         tick();
      end
      in_valid = 1'b0; in_is_coeff = 1'b0; clr = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fir_feeder.md
FIR_FEEDER -- requirements
Module: fir_feeder

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, upstream word valid.
REQ-004 SHALL have port in_data, input, 16, upstream word.
REQ-005 SHALL have port in_is_coeff, input, 1, 1 = coefficient word, 0 = sample word.
REQ-006 SHALL have port in_ready, output, 1, word accepted when in_valid & in_ready at an edge.
REQ-007 SHALL have port clr, input, 1, synchronous clear.
REQ-008 SHALL have port modwait, input, 1, filter busy indication.
REQ-009 SHALL have port sample_data, output, 16, sample presented to filter.
REQ-010 SHALL have port fir_coefficient, output, 16, coefficient presented to filter.
REQ-011 SHALL have port data_ready, output, 1, one-cycle sample strobe.
REQ-012 SHALL have port load_coeff, output, 1, one-cycle coefficient strobe.
REQ-013 SHALL have port fifo_count, output, 4, sample FIFO occupancy 0..8.
REQ-014 SHALL have port timeout, output, 1, sticky handshake-timeout flag.

Function
REQ-015 Sample FIFO SHALL be 8 deep x 16 bit; in_ready for samples = (fifo_count < 8), registered occupancy only; a pop in the same cycle SHALL NOT make a full FIFO accept.
REQ-016 Coefficient bank SHALL be 4 x 16 bit, written in order index 0..3; in_ready for coefficients = 0 while the coefficient load is pending or in progress, else 1.
REQ-017 Writing index 3 SHALL set coeff_pending and reset the write index to 0.
REQ-018 FSM states: IDLE, C_PULSE, C_WAIT_HI, C_WAIT_LO, S_PULSE, S_WAIT_HI, S_WAIT_LO.
REQ-019 IDLE: if coeff_pending and modwait=0 -> C_PULSE (k=0); else if fifo_count>0 and modwait=0 -> S_PULSE; coefficient load has priority.
REQ-020 C_PULSE: load_coeff=1 for exactly one cycle, fir_coefficient=bank[k] -> C_WAIT_HI.
REQ-021 C_WAIT_HI: wait modwait=1 -> C_WAIT_LO; C_WAIT_LO: wait modwait=0 -> k++; k<4 -> C_PULSE, k=4 -> clear coeff_pending, IDLE.
REQ-022 S_PULSE: pop FIFO head into sample_data register, data_ready=1 for exactly one cycle -> S_WAIT_HI; S_WAIT_HI/S_WAIT_LO as REQ-021, S_WAIT_LO exits to IDLE.
REQ-023 sample_data and fir_coefficient SHALL be registered and held stable from strobe until the next strobe of the same kind.
REQ-024 Latency: sample accepted into empty FIFO at edge N with FSM idle and modwait=0 SHALL give data_ready high in the cycle after edge N+2.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo 8.
REQ-026 clr=1 SHALL empty FIFO, zero write index, clear coeff_pending and timeout, force IDLE; clr overrides a simultaneous push.

Reset
REQ-027 On n_rst=0: FSM IDLE, FIFO empty, fifo_count=0, bank and write index 0, coeff_pending=0, sample_data=0, fir_coefficient=0, data_ready=0, load_coeff=0, timeout=0.
REQ-028 Reset mid-sequence SHALL abandon any load; no strobe SHALL occur in the first cycle after release.

Configuration
REQ-029 Macro FIR_FEEDER_TIMEOUT_EN defined: a 5-bit counter runs in every WAIT state; 16 cycles without the awaited modwait level SHALL set timeout, abort the sequence (clear coeff_pending on coefficient abort), return IDLE.
REQ-030 Macro FIR_FEEDER_TIMEOUT_EN undefined: WAIT states wait indefinitely; timeout tied 0; no counter logic.

Verification
REQ-031 Push samples 0x0010,0x0020 into empty FIFO, modwait model 1 for 3 cycles after each strobe -> two data_ready pulses, sample_data 0x0010 then 0x0020, fifo_count returns to 0.
REQ-032 Write coeffs 0x1111,0x2222,0x3333,0x4444 while sample 0x0055 queued -> four load_coeff pulses with those values in order before data_ready with 0x0055.
REQ-033 Push 9 samples with modwait held 1 -> in_ready=0 after 8, fifo_count=8, ninth word dropped.
REQ-034 Assert n_rst during C_WAIT_LO at k=2 -> all outputs zero, no strobe on release, coefficient writes accepted again.
REQ-035 With FIR_FEEDER_TIMEOUT_EN, modwait stuck 0 after data_ready -> timeout=1 after 16 cycles, FSM IDLE; clr pulse -> timeout=0.
